// File: rtl/sonic_vc_st_pkg.sv
// sonic_vc_st_pkg: shared beat layout and sizing helpers
// for the VC Avalon-ST timing adapter.
package sonic_vc_st_pkg;

  localparam int MAX_RL = 4;

  localparam int DFLT_DATA_W    = 128;
  localparam int DFLT_CHANNEL_W = 1;
  localparam int DFLT_EMPTY_W   = 1;

  typedef struct packed {
    logic [DFLT_DATA_W-1:0]    data;
    logic [DFLT_CHANNEL_W-1:0] channel;
    logic                      error;
    logic                      sop;
    logic                      eop;
    logic [DFLT_EMPTY_W-1:0]   empty;
  } st_beat_t;

  function automatic int min_depth(input int in_rl,
                                   input int out_rl);
    return in_rl + out_rl + 1;
  endfunction

  function automatic int beat_w(input int dw,
                                input int cw,
                                input int ew);
    return dw + cw + ew + 3;
  endfunction

endpackage

// File: rtl/sonic_vc_st_timing_adapter_skid_fifo.sv
// sonic_vc_st_skid_fifo: register-file FIFO with wrapping
// pointers and an occupancy counter; head is read combinationally.
module sonic_vc_st_skid_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_wdata,
  output logic [W-1:0]           o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_wr;
  logic          w_rd;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_level = r_cnt;
  assign o_rdata = r_mem[r_rptr];

  // a pop in the same cycle frees the slot a push at full lands in
  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/sonic_vc_st_timing_adapter.sv
// sonic_vc_st_timing_adapter: bridges Avalon-ST ready latencies
// IN_RL -> OUT_RL through a credit-managed skid FIFO.
module sonic_vc_st_timing_adapter
  import sonic_vc_st_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int CHANNEL_W = 1,
  parameter int EMPTY_W   = 1,
  parameter int IN_RL     = 0,
  parameter int OUT_RL    = 2,
  parameter int DEPTH     = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   in_ready,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [CHANNEL_W-1:0]   in_channel,
  input  logic                   in_error,
  input  logic                   in_startofpacket,
  input  logic                   in_endofpacket,
  input  logic [EMPTY_W-1:0]     in_empty,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [CHANNEL_W-1:0]   out_channel,
  output logic                   out_error,
  output logic                   out_startofpacket,
  output logic                   out_endofpacket,
  output logic [EMPTY_W-1:0]     out_empty,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   overflow_err
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int BW = beat_w(DATA_W, CHANNEL_W, EMPTY_W);
  localparam int OW = 4;
  localparam int SW = ((LW > OW) ? LW : OW) + 1;

  if (DEPTH < min_depth(IN_RL, OUT_RL) || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0 ||
      IN_RL < 0 || IN_RL > MAX_RL ||
      OUT_RL < 0 || OUT_RL > MAX_RL ||
      CHANNEL_W < 1 || EMPTY_W < 1) begin : g_bad_cfg
    $error("sonic_vc_st_timing_adapter: illegal configuration");
  end

  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic [CHANNEL_W-1:0] channel;
    logic                 error;
    logic                 sop;
    logic                 eop;
    logic [EMPTY_W-1:0]   empty;
  } beat_t;

  beat_t         w_in_beat;
  beat_t         w_out_beat;
  logic [BW-1:0] w_rdata;
  logic          w_grant_d;
  logic          w_ok;
  logic          w_accept;
  logic          w_viol;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic [OW-1:0] w_outst;
  logic [SW-1:0] w_used;
  logic          r_ovf;

  // in-flight grants are reserved space; a same-cycle pop is not credited
  assign w_used   = SW'(fill_level) + SW'(w_outst);
  assign in_ready = reset_n && !w_full && (w_used < SW'(DEPTH));

  if (IN_RL == 0) begin : g_in_rl0
    assign w_grant_d = in_ready;
    assign w_outst   = '0;
  end else begin : g_in_rl
    logic [IN_RL-1:0] r_gsr;
    logic [OW-1:0]    r_outst;
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_gsr   <= '0;
        r_outst <= '0;
      end else begin
        r_gsr   <= IN_RL'({r_gsr, in_ready});
        r_outst <= r_outst + OW'(in_ready) - OW'(r_gsr[IN_RL-1]);
      end
    end
    assign w_grant_d = r_gsr[IN_RL-1];
    assign w_outst   = r_outst;
  end

  if (OUT_RL == 0) begin : g_out_rl0
    assign w_ok  = 1'b1;
    assign w_pop = out_valid && out_ready;
  end else begin : g_out_rl
    logic [OUT_RL-1:0] r_osr;
    always_ff @(posedge clk) begin
      if (!reset_n) r_osr <= '0;
      else          r_osr <= OUT_RL'({r_osr, out_ready});
    end
    assign w_ok  = r_osr[OUT_RL-1];
    assign w_pop = out_valid;
  end

  assign w_accept  = reset_n && in_valid && w_grant_d;
  assign w_viol    = in_valid && !w_grant_d;
  assign out_valid = reset_n && !w_empty && w_ok;

  assign w_in_beat = {in_data, in_channel, in_error,
                      in_startofpacket, in_endofpacket, in_empty};

  sonic_vc_st_skid_fifo #(
    .W     (BW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_wdata (w_in_beat),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fill_level)
  );

  assign w_out_beat = w_rdata;
  assign {out_data, out_channel, out_error,
          out_startofpacket, out_endofpacket, out_empty} = w_out_beat;

  always_ff @(posedge clk) begin
    if (!reset_n)    r_ovf <= 1'b0;
    else if (w_viol) r_ovf <= 1'b1;
  end

  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_sonic_vc_st_timing_adapter.sv
// tb_sonic_vc_st_timing_adapter: three adapter configurations
// driven from a step table against a queue-based reference model.
module tb_sonic_vc_st_timing_adapter;

  localparam int DW    = 128;
  localparam int CW    = 2;
  localparam int EW    = 4;
  localparam int DEPTH = 8;
  localparam int NLOG  = 8192;
  localparam int NSTEP = 11;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ch;
    logic          err;
    logic          sop;
    logic          eop;
    logic [EW-1:0] emp;
  } beat_t;

  typedef struct {
    int inst;
    int nbeats;
    int snk;
    bit inj;
    int rstc;
    int cycles;
    bit do_chk;
    int fill;
    bit rdy;
    bit vld;
    bit ovf;
  } step_t;

  logic clk;
  int   checks   = 0;
  int   failures = 0;

  int src_left [3] = '{0, 0, 0};
  int snk_mode [3] = '{1, 1, 1};
  bit inj_req  [3] = '{0, 0, 0};
  int rst_cnt  [3] = '{3, 3, 3};
  int dut_rx   [3] = '{0, 0, 0};

  logic [3:0] mon_fill [3];
  logic       mon_rdy  [3];
  logic       mon_vld  [3];
  logic       mon_ovf  [3];

  task automatic chk(input string nm, input int inst,
                     input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d: got %0h want %0h", nm, inst, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int IRL = (g == 0) ? 0 : (g == 1) ? 2 : 1;
    localparam int ORL = (g == 0) ? 2 : (g == 1) ? 0 : 3;

    logic          rst_n;
    logic          in_ready;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_channel;
    logic          in_error;
    logic          in_sop;
    logic          in_eop;
    logic [EW-1:0] in_empty;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_channel;
    logic          out_error;
    logic          out_sop;
    logic          out_eop;
    logic [EW-1:0] out_empty;
    logic [3:0]    fill_level;
    logic          overflow_err;

    sonic_vc_st_timing_adapter #(
      .DATA_W    (DW),
      .CHANNEL_W (CW),
      .EMPTY_W   (EW),
      .IN_RL     (IRL),
      .OUT_RL    (ORL),
      .DEPTH     (DEPTH)
    ) u_dut (
      .clk               (clk),
      .reset_n           (rst_n),
      .in_ready          (in_ready),
      .in_valid          (in_valid),
      .in_data           (in_data),
      .in_channel        (in_channel),
      .in_error          (in_error),
      .in_startofpacket  (in_sop),
      .in_endofpacket    (in_eop),
      .in_empty          (in_empty),
      .out_ready         (out_ready),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_channel       (out_channel),
      .out_error         (out_error),
      .out_startofpacket (out_sop),
      .out_endofpacket   (out_eop),
      .out_empty         (out_empty),
      .fill_level        (fill_level),
      .overflow_err      (overflow_err)
    );

    assign mon_fill[g] = fill_level;
    assign mon_rdy[g]  = in_ready;
    assign mon_vld[g]  = out_valid;
    assign mon_ovf[g]  = overflow_err;

    // cycle-indexed model: the queue is the buffer, the logs hold
    // every grant and sink-ready value ever issued
    initial begin : model
      beat_t q[$];
      bit    li [NLOG];
      bit    lo [NLOG];
      beat_t b;
      int    n, base, pend, ks, seq;
      bit    armed, rstv, erdy, slot, okx, evld;
      bit    push, pop, viol, flag;
      n = 0; base = 0; seq = 0;
      armed = 1'b0; flag = 1'b0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_data = '0; in_channel = '0; in_error = 1'b0;
      in_sop = 1'b0; in_eop = 1'b0; in_empty = '0;
      forever begin
        @(negedge clk);
        rstv = (rst_cnt[g] > 0);
        if (rstv) rst_cnt[g]--;
        pend = 0;
        for (int k = n - IRL; k < n; k++)
          if (k >= base) pend += int'(li[k]);
        erdy = !rstv && ((q.size() + pend) < DEPTH);
        ks   = n - IRL;
        slot = (IRL == 0) ? erdy : (!rstv && ks >= base && li[ks]);
        okx  = (ORL == 0) ? 1'b1 :
               ((n - ORL) >= base && lo[n - ORL]);
        evld = !rstv && (q.size() > 0) && okx;
        case (snk_mode[g])
          0:       out_ready = 1'b0;
          1:       out_ready = 1'b1;
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        b.data = {$urandom, $urandom, $urandom, 32'(seq)};
        b.ch   = CW'($urandom);
        b.err  = 1'($urandom);
        b.sop  = 1'($urandom);
        b.eop  = 1'($urandom);
        b.emp  = EW'($urandom);
        push = 1'b0;
        viol = 1'b0;
        if (slot && src_left[g] > 0) begin
          push = 1'b1;
          src_left[g]--;
          seq++;
        end else if (inj_req[g] && !slot && !rstv) begin
          viol = 1'b1;
          inj_req[g] = 1'b0;
        end
        rst_n      = !rstv;
        in_valid   = push || viol;
        in_data    = b.data;
        in_channel = b.ch;
        in_error   = b.err;
        in_sop     = b.sop;
        in_eop     = b.eop;
        in_empty   = b.emp;
        pop = evld && (ORL != 0 || out_ready);
        #1;
        if (out_valid && (ORL != 0 || out_ready)) dut_rx[g]++;
        if (armed) begin
          chk("in_ready", g, 160'(in_ready), 160'(erdy));
          chk("out_valid", g, 160'(out_valid), 160'(evld));
          chk("fill_level", g, 160'(fill_level), 160'(q.size()));
          chk("overflow_err", g, 160'(overflow_err), 160'(flag));
          if (evld)
            chk("payload", g,
                160'({out_data, out_channel, out_error,
                      out_sop, out_eop, out_empty}),
                160'(q[0]));
        end
        li[n] = erdy;
        lo[n] = out_ready;
        if (rstv) begin
          q.delete();
          flag  = 1'b0;
          base  = n + 1;
          armed = 1'b1;
        end else begin
          if (pop) void'(q.pop_front());
          if (push) q.push_back(b);
          if (viol) flag = 1'b1;
        end
        n++;
      end
    end
  end

  initial begin : main
    step_t st [NSTEP];
    // inst nbeats snk inj rstc cycles do_chk fill rdy vld ovf
    st[0]  = '{0,   16, 1, 0, 0,   22, 1, 0, 1, 0, 0};
    st[1]  = '{1,   40, 0, 0, 0,   20, 1, 8, 0, 1, 0};
    st[2]  = '{1,    0, 0, 1, 0,    4, 1, 8, 0, 1, 1};
    st[3]  = '{1,    0, 1, 0, 0,   12, 1, 5, 1, 1, 1};
    st[4]  = '{1,    0, 1, 0, 0,   40, 1, 0, 1, 0, 1};
    st[5]  = '{0,    0, 0, 0, 0,    4, 0, 0, 0, 0, 0};
    st[6]  = '{0,    5, 0, 0, 0,    8, 1, 5, 1, 0, 0};
    st[7]  = '{0,    0, 0, 0, 1,    2, 1, 0, 1, 0, 0};
    st[8]  = '{0,    4, 1, 0, 0,   12, 1, 0, 1, 0, 0};
    st[9]  = '{2, 1000, 2, 0, 0, 3000, 0, 0, 0, 0, 0};
    st[10] = '{2,    0, 1, 0, 0,  200, 1, 0, 1, 0, 0};

    repeat (4) @(negedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("rst_fill", k, 160'(mon_fill[k]), 160'(0));
      chk("rst_rdy", k, 160'(mon_rdy[k]), 160'(1));
      chk("rst_vld", k, 160'(mon_vld[k]), 160'(0));
      chk("rst_ovf", k, 160'(mon_ovf[k]), 160'(0));
    end

    for (int i = 0; i < NSTEP; i++) begin
      src_left[st[i].inst] += st[i].nbeats;
      snk_mode[st[i].inst]  = st[i].snk;
      inj_req[st[i].inst]   = st[i].inj;
      rst_cnt[st[i].inst]  += st[i].rstc;
      repeat (st[i].cycles) @(negedge clk);
      #2;
      if (st[i].do_chk) begin
        chk($sformatf("step%0d_fill", i), st[i].inst,
            160'(mon_fill[st[i].inst]), 160'(st[i].fill));
        chk($sformatf("step%0d_rdy", i), st[i].inst,
            160'(mon_rdy[st[i].inst]), 160'(st[i].rdy));
        chk($sformatf("step%0d_vld", i), st[i].inst,
            160'(mon_vld[st[i].inst]), 160'(st[i].vld));
        chk($sformatf("step%0d_ovf", i), st[i].inst,
            160'(mon_ovf[st[i].inst]), 160'(st[i].ovf));
      end
      if (i == 0)
        chk("burst16_rx", 0, 160'(dut_rx[0]), 160'(16));
    end

    chk("random_rx", 2, 160'(dut_rx[2]), 160'(1000));
    chk("random_src_done", 2, 160'(src_left[2]), 160'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
